// File: rtl/adc_event_reader.sv
// Event queue on the consumer side of the ADC event detector: buffers strobed
// events with their sequence numbers, tracks drops and sequence gaps, raises irq.
module adc_event_reader #(
  parameter int DEPTH     = 8,
  parameter int IRQ_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [9:0]                 adc_event,
  input  logic [5:0]                 adc_event_seq,
  input  logic                       adc_event_intr,
  input  logic                       rd_req,
  output logic [15:0]                rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       fifo_empty,
  output logic                       fifo_full,
  output logic [7:0]                 ovf_cnt,
  output logic                       seq_err,
  input  logic                       irq_en,
  input  logic                       clr_err,
  output logic                       irq,
  output logic                       seq_track_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {SEQ_IDLE = 1'b0, SEQ_TRACK = 1'b1} seq_state_t;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [5:0]    last_seq;
  seq_state_t    seq_state;

  logic push;
  logic pop;
  logic drop;
  logic gap;

  // Read port: rd_req is a request with no ready/backpressure; it is honoured
  // only when an entry is stored, and the popped entry is presented one cycle
  // later as a single-cycle rd_valid pulse. rd_data holds between pulses.
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_count = count;
  assign pop        = rd_req && !fifo_empty;
  assign push       = adc_event_intr && (!fifo_full || pop);
  assign drop       = adc_event_intr && !push;
  assign gap        = adc_event_intr && (seq_state == SEQ_TRACK) &&
                      (adc_event_seq != 6'(last_seq + 6'd1));
  assign seq_track_dbg = (seq_state == SEQ_TRACK);

  // Storage has no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {adc_event_seq, adc_event};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Error tracking: a new drop or gap in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt   <= '0;
      seq_err   <= 1'b0;
      last_seq  <= '0;
      seq_state <= SEQ_IDLE;
    end else begin
      if (drop) begin
        if (clr_err)              ovf_cnt <= 8'd1;
        else if (ovf_cnt != 8'hff) ovf_cnt <= ovf_cnt + 8'd1;
      end else if (clr_err) begin
        ovf_cnt <= '0;
      end
      seq_err <= (seq_err && !clr_err) || gap;
      if (adc_event_intr) last_seq <= adc_event_seq;
      if (clr_err)             seq_state <= SEQ_IDLE;
      else if (adc_event_intr) seq_state <= SEQ_TRACK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= irq_en && ((count >= CW'(IRQ_LEVEL)) || seq_err || (ovf_cnt != 8'd0));
  end

endmodule

// File: doc/adc_event_reader.md
# adc_event_reader

Consumer side of the ADC event detector's output interface. Samples `adc_event`, `adc_event_seq` and `adc_event_intr` every cycle, and queues each signalled event with its sequence number in a small FIFO. The FIFO is drained by a simple read-request port on the SoC register side. The block also tracks overflow and sequence gaps, and raises a maskable level interrupt toward the CPU.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `IRQ_LEVEL`, 1: fill level at or above which `irq` asserts; range 1..DEPTH.
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, synchronous, active-high.
- `adc_event` in 10: event code from the detector.
- `adc_event_seq` in 6: event sequence number from the detector.
- `adc_event_intr` in 1: event strobe; high for one cycle per event.
- `rd_req` in 1: pop request from the register side.
- `rd_data` out 16: popped entry, `{seq[5:0], event[9:0]}`.
- `rd_valid` out 1: `rd_data` is valid this cycle (one-cycle pulse).
- `fifo_count` out clog2(DEPTH)+1: current number of stored entries.
- `fifo_empty` out 1: high when `fifo_count` == 0.
- `fifo_full` out 1: high when `fifo_count` == DEPTH.
- `ovf_cnt` out 8: count of dropped events; saturates at 255.
- `seq_err` out 1: sticky; a sequence gap was detected.
- `irq_en` in 1: interrupt enable.
- `clr_err` in 1: one-cycle pulse; clears `ovf_cnt`, `seq_err` and the sequence-check history.
- `irq` out 1: level interrupt to the CPU.

## Operation
- **Push**
  - A push occurs when `adc_event_intr` is high at a rising edge.
  - The entry stored is `{adc_event_seq, adc_event}`, sampled at that same edge.
  - If the FIFO is full and there is no simultaneous pop, the event is dropped and `ovf_cnt` increments (saturating at 255).
- **Pop**
  - A pop occurs when `rd_req` is high and `fifo_empty` is low at a rising edge.
  - The head entry appears on `rd_data` with `rd_valid` high in the following cycle.
  - `rd_req` while empty is ignored: no `rd_valid`, and no error is flagged.
  - `rd_data` holds its last value when `rd_valid` is low.
- **Simultaneous push and pop**
  - When full: both take effect, the push is accepted, and `fifo_count` is unchanged.
  - When empty: only the push takes effect. There is no bypass; the new entry is readable from the next cycle.
- **Pointers:** read and write pointers are clog2(DEPTH) bits wide and wrap naturally modulo DEPTH.
- **Sequence checker** (evaluated on every strobe, including dropped events)
  - States: IDLE (no history) and TRACK (`last_seq` valid).
  - IDLE plus a strobe: capture `last_seq` and go to TRACK; no check is performed.
  - TRACK plus a strobe: if `adc_event_seq` != (`last_seq` + 1) mod 64, set `seq_err`. Update `last_seq` in either case.
  - `clr_err` returns the checker to IDLE.
- **Error clear**
  - `clr_err` zeroes `ovf_cnt` and `seq_err`.
  - If a new overflow or sequence error occurs in the same cycle as `clr_err`, the set wins: `ovf_cnt` becomes 1, or `seq_err` stays 1.
  - `clr_err` does not flush the FIFO.
- **Interrupt:** `irq` = `irq_en` & ((`fifo_count` >= IRQ_LEVEL) | `seq_err` | (`ovf_cnt` != 0)). It is a registered output.

## Timing
- **Reset values:** `rd_data` = 0, `rd_valid` = 0, `fifo_count` = 0, `fifo_empty` = 1, `fifo_full` = 0, `ovf_cnt` = 0, `seq_err` = 0, `irq` = 0. Pointers are 0 and the sequence checker is in IDLE.
- **Latencies**
  - Strobe at edge N: `fifo_count` is updated after edge N; `irq` reflects the new count after edge N+1.
  - `rd_req` at edge N: `rd_valid` and `rd_data` are valid between edges N and N+1.
- **Throughput:** one push and one pop per cycle sustained.
- **Reset mid-operation:** `rst` high at any edge discards the FIFO contents and any pending `rd_valid`; all outputs return to their reset values at that edge.

## Test plan
- **Fill, drain and wrap:** reset, then 3 strobes with seq 0,1,2 and events 0x011, 0x022, 0x033, then 3 `rd_req` → `rd_data` = 0x0011, 0x0422, 0x0833 in order; `fifo_count` goes 3→0; `seq_err` = 0. Repeat 10 times so the pointers wrap; data order is preserved.
- **Overflow with saturation:** 8 strobes with seq 0..7 fill the FIFO (`fifo_full` = 1). Then 300 more strobes with consecutive seq values and no reads → `ovf_cnt` = 255, `seq_err` = 0, and the first 8 entries read back intact. Then `clr_err` → `ovf_cnt` = 0.
- **Simultaneous push and pop:**
  - Full FIFO, strobe plus `rd_req` in the same cycle → `fifo_count` stays 8 and `ovf_cnt` stays 0.
  - Empty FIFO, strobe plus `rd_req` in the same cycle → no `rd_valid`; `fifo_count` = 1.
- **Sequence gap:**
  - Seq 5, 6, 8 → `seq_err` = 1 after the third strobe.
  - `clr_err`, then seq 20, 21 → `seq_err` remains 0.
  - Seq 63 followed by 0 → no error (wrap is legal).
- **Interrupt with IRQ_LEVEL = 4:**
  - `irq_en` = 1: 3 events → `irq` = 0; 4th event → `irq` = 1 one cycle after the count reaches 4; pop one → `irq` = 0.
  - `irq_en` = 0 with `seq_err` = 1 → `irq` = 0.
- **Reset mid-operation:** 5 events queued, `rd_req` pulsed, then `rst` asserted at the next edge → `rd_valid` = 0, `fifo_count` = 0, `fifo_empty` = 1. The first strobe after reset performs no sequence check.
